// File: rtl/stopwatch_display.sv
// stopwatch_display: multiplexed 4-digit 7-segment driver with tear-free frame snapshot.
// Optional macro BLANK_LEADING_ZERO_EN: blank the tens-of-seconds digit when it is zero.
module stopwatch_display #(
  parameter int unsigned SCAN_DIV     = 10000,
  parameter bit          COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic [3:0] hund_tens,
  input  logic [3:0] hund_ones,
  input  logic       freeze,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       digit_err
);

  localparam int unsigned PW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          tick;
  logic          frame;

  // Active-high internal copies of the pin drivers
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic       err_q, err_d;
  logic [3:0] digit;

  assign tick  = (presc_q == PMAX);
  assign frame = tick && (idx_q == 2'd3);

  // Prescaler, slot index and frame-boundary snapshot next state
  always_comb begin
    presc_d = presc_q + PONE;
    idx_d   = idx_q;
    snap_d  = snap_q;
    if (tick) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end
    if (frame && !freeze) begin
      snap_d = {sec_tens, sec_ones, hund_tens, hund_ones};
    end
  end

  // Digit select and segment decode for the slot being scanned
  always_comb begin
    digit = 4'd0;
    an_d  = 4'b0000;
    dp_d  = 1'b0;
    unique case (idx_q)
      2'd0: begin digit = snap_q[3:0];   an_d = 4'b0001; end
      2'd1: begin digit = snap_q[7:4];   an_d = 4'b0010; end
      2'd2: begin digit = snap_q[11:8];  an_d = 4'b0100;
                  dp_d  = 1'b1; end
      2'd3: begin digit = snap_q[15:12]; an_d = 4'b1000; end
    endcase
    err_d = 1'b0;
    unique case (digit)
      4'd0:    seg_d = 7'b0111111;
      4'd1:    seg_d = 7'b0000110;
      4'd2:    seg_d = 7'b1011011;
      4'd3:    seg_d = 7'b1001111;
      4'd4:    seg_d = 7'b1100110;
      4'd5:    seg_d = 7'b1101101;
      4'd6:    seg_d = 7'b1111101;
      4'd7:    seg_d = 7'b0000111;
      4'd8:    seg_d = 7'b1111111;
      4'd9:    seg_d = 7'b1101111;
      default: begin
        seg_d = 7'b1000000;
        err_d = 1'b1;
      end
    endcase
`ifdef BLANK_LEADING_ZERO_EN
    if (idx_q == 2'd3 && digit == 4'd0) begin
      seg_d = 7'b0000000;
      err_d = 1'b0;
    end
`endif
  end

  // Scan state and snapshot registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'h0000;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  // Registered output stage, one cycle behind the scan state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      an_q  <= 4'b0000;
      seg_q <= 7'b0000000;
      dp_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      err_q <= err_d;
    end
  end

  assign an        = COMMON_ANODE ? ~an_q  : an_q;
  assign seg       = COMMON_ANODE ? ~seg_q : seg_q;
  assign dp        = COMMON_ANODE ? ~dp_q  : dp_q;
  assign digit_err = err_q;

endmodule
